// File: rtl/pipe_reg.sv
// WIDTH-bit, DEPTH-stage register delay line with per-stage valid bits, stall,
// synchronous flush, a selectable tap output and a registered occupancy count.
module pipe_reg #(
    parameter int unsigned           WIDTH     = 8,
    parameter int unsigned           DEPTH     = 4,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0,
    localparam int unsigned          TAPW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned          CNTW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [TAPW-1:0]  tap,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_valid,
    output logic [CNTW-1:0]  count
);

    // Valid semantics: d is captured only on a posedge with en=1 and flush=0;
    // d_valid travels with the data, so a bubble still shifts its data word.
    // There is no ready; en is the only backpressure and it stalls every stage.

    logic [WIDTH-1:0] stage [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_next;
    logic [CNTW-1:0]  cnt_next;

    always_comb begin
        v_next = v;
        if (flush) begin
            v_next = '0;
        end else if (en) begin
            v_next[0] = d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                v_next[i] = v[i-1];
            end
        end
    end

    // Count is recomputed from the next valid vector, so it can never wrap.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + CNTW'(v_next[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VAL;
            end
            v     <= '0;
            count <= '0;
        end else begin
            v     <= v_next;
            count <= cnt_next;
            if (!flush && en) begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end
    end

    assign q       = stage[DEPTH-1];
    assign q_valid = v[DEPTH-1];

    // Out-of-range taps fall through to the reset value with valid low.
    always_comb begin
        tap_q     = RESET_VAL;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap == TAPW'(i)) begin
                tap_q     = stage[i];
                tap_valid = v[i];
            end
        end
    end

endmodule
